// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit/receive blocks.
//   - tx_state_e   : transmit FSM state encoding
//   - PARITY_*     : values for the PARITY parameter
//   - frame_bits() : total bit periods in one frame for a given framing
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // start + payload + optional parity + stop bits
  function automatic int frame_bits(input int data_bits, input int parity,
                                    input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
//   Oversampled UART transmitter. Serialises a word as start bit, DATA_BITS
//   payload bits LSB first, optional parity bit and STOP_BITS stop bits.
//   Bit timing is SAMPLE_RATIO pulses of the external sample_tick per bit.
//   A one-entry holding register in front of the shifter lets the producer
//   queue the next word while a frame is on the line, so consecutive frames
//   follow with no idle bits.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active high
//   sample_tick  one-clk enable at baud * SAMPLE_RATIO
//   tx_data      word to send, captured when tx_valid && tx_ready
//   tx_valid     producer has a word
//   tx_ready     holding register empty
//   dout         serial line, idle high (registered)
//   busy         frame in progress (START .. STOP)
//   tx_done      one-clk pulse after the last stop bit has been sent
// ---------------------------------------------------------------------------
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int SAMPLE_RATIO = 16,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 dout,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int TW = $clog2(SAMPLE_RATIO);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] LAST_TICK = TW'(SAMPLE_RATIO - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  // holding register
  logic                 buf_full_q;
  logic [DATA_BITS-1:0] buf_q;

  // FSM / shifter state
  tx_state_e            state_q, state_n;
  logic [TW-1:0]        tick_q,  tick_n;
  logic [BW-1:0]        bit_q,   bit_n;    // data index in DATA, stop index in STOP
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 par_q,   par_n;
  logic                 pend_q,  pend_n;   // shifter loaded in IDLE, waiting for a tick
  logic                 dout_q,  dout_n;
  logic                 done_q,  done_n;

  logic accept, bit_end, frame_end, load, par_calc;

  assign accept    = tx_valid && !buf_full_q;
  assign bit_end   = sample_tick && (tick_q == LAST_TICK);
  assign frame_end = (state_q == ST_STOP) && bit_end && (bit_q == LAST_STOP);

  // The shifter takes the buffered word either when idle and empty, or on the
  // very tick the final stop bit finishes so the next start bit follows at once.
  assign load      = buf_full_q && (((state_q == ST_IDLE) && !pend_q) || frame_end);

  // Parity over the whole word at load time; odd parity inverts the XOR.
  assign par_calc  = (^buf_q) ^ (PARITY == PARITY_ODD);

  assign tx_ready  = !buf_full_q;
  assign busy      = (state_q != ST_IDLE);
  assign dout      = dout_q;
  assign tx_done   = done_q;

  // -------------------------------------------------------------------------
  // Holding register. accept and load are mutually exclusive: accept needs an
  // empty buffer, load needs a full one, so the buffer is never double-loaded.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full_q <= 1'b0;
      buf_q      <= '0;
    end else if (accept) begin
      buf_full_q <= 1'b1;
      buf_q      <= tx_data;
    end else if (load) begin
      buf_full_q <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      pend_q  <= 1'b0;
      dout_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      tick_q  <= tick_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      par_q   <= par_n;
      pend_q  <= pend_n;
      dout_q  <= dout_n;
      done_q  <= done_n;
    end
  end

  // -------------------------------------------------------------------------
  // Next state / outputs. dout_n only moves on a tick, so the line changes
  // only on tick edges and freezes whenever sample_tick is held low.
  // -------------------------------------------------------------------------
  always_comb begin
    state_n = state_q;
    tick_n  = tick_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    par_n   = par_q;
    pend_n  = pend_q;
    dout_n  = dout_q;
    done_n  = 1'b0;

    if (load) begin
      shift_n = buf_q;
      par_n   = par_calc;
      pend_n  = 1'b1;
    end

    // tick counter runs only inside a frame and wraps at each bit boundary
    if (sample_tick && (state_q != ST_IDLE))
      tick_n = bit_end ? '0 : tick_q + TW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (sample_tick && pend_q) begin
          state_n = ST_START;
          tick_n  = '0;
          pend_n  = 1'b0;
          dout_n  = 1'b0;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_n = ST_DATA;
          bit_n   = '0;
          dout_n  = shift_q[0];
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == LAST_DATA) begin
            bit_n = '0;
            if (PARITY != PARITY_NONE) begin
              state_n = ST_PARITY;
              dout_n  = par_q;
            end else begin
              state_n = ST_STOP;
              dout_n  = 1'b1;
            end
          end else begin
            // bit 0 is already on the line; shift and present the next one
            bit_n   = bit_q + BW'(1);
            shift_n = shift_q >> 1;
            dout_n  = shift_q[1];
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          state_n = ST_STOP;
          bit_n   = '0;
          dout_n  = 1'b1;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == LAST_STOP) begin
            done_n = 1'b1;
            bit_n  = '0;
            if (buf_full_q) begin
              // chained frame: start bit begins on this same tick edge
              state_n = ST_START;
              pend_n  = 1'b0;
              dout_n  = 1'b0;
            end else begin
              state_n = ST_IDLE;
              dout_n  = 1'b1;
            end
          end else begin
            bit_n = bit_q + BW'(1);
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        dout_n  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;
  import uart_pkg::*;

  localparam int R        = 16;  // sample ticks per bit
  localparam int TICK_DIV = 4;   // clk cycles per sample tick
  localparam int NI       = 4;   // 0 plain, 1 even parity, 2 odd parity, 3 two stop bits

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_tick = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic [NI-1:0] tx_valid = '0;
  logic [NI-1:0] tx_ready, dout, busy, tx_done;

  always #5 clk = ~clk;

  uart_tx_engine #(.DATA_BITS(8), .SAMPLE_RATIO(R), .PARITY(PARITY_NONE), .STOP_BITS(1)) u_plain (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .tx_data(tx_data), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .dout(dout[0]), .busy(busy[0]), .tx_done(tx_done[0]));
  uart_tx_engine #(.DATA_BITS(8), .SAMPLE_RATIO(R), .PARITY(PARITY_EVEN), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .tx_data(tx_data), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .dout(dout[1]), .busy(busy[1]), .tx_done(tx_done[1]));
  uart_tx_engine #(.DATA_BITS(8), .SAMPLE_RATIO(R), .PARITY(PARITY_ODD), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .tx_data(tx_data), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .dout(dout[2]), .busy(busy[2]), .tx_done(tx_done[2]));
  uart_tx_engine #(.DATA_BITS(8), .SAMPLE_RATIO(R), .PARITY(PARITY_NONE), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .tx_data(tx_data), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .dout(dout[3]), .busy(busy[3]), .tx_done(tx_done[3]));

  // scoreboard entry: seq[0] is the first bit on the line
  typedef struct {
    int          inst;
    logic [11:0] seq;
    int          nbits;
    bit          b2b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // sample tick generator; stall changes only at posedge+1
  logic tick_stall = 1'b0;
  int   tick_div   = 0;
  initial forever begin
    @(negedge clk);
    if (tick_stall) sample_tick = 1'b0;
    else begin
      tick_div    = (tick_div + 1) % TICK_DIV;
      sample_tick = (tick_div == 0);
    end
  end

  logic tick_seen = 1'b0;
  always @(posedge clk) tick_seen <= sample_tick;

  // ---------------- monitor: one line sample per tick ----------------
  bit          in_frame [NI] = '{default: 1'b0};
  bit          ign      [NI] = '{default: 1'b0};
  bit          incons   [NI] = '{default: 1'b0};
  int          samp     [NI] = '{default: 0};
  int          gap      [NI] = '{default: 0};
  int          done_cnt [NI] = '{default: 0};
  int          frames   [NI] = '{default: 0};
  logic [11:0] obs      [NI];
  exp_t        cur      [NI];

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++)
      if (!rst && tx_done[k]) done_cnt[k]++;
    if (rst) begin
      for (int k = 0; k < NI; k++) begin
        in_frame[k] = 1'b0;
        gap[k]      = 0;
      end
    end else if (tick_seen) begin
      for (int k = 0; k < NI; k++) begin
        if (!in_frame[k]) begin
          if (dout[k] == 1'b0) begin
            checks++;
            if (sb.size() == 0 || sb[0].inst != k) begin
              errors++;
              $display("FAIL frame_start inst=%0d got an unexpected start bit, queued=%0d", k, sb.size());
              cur[k] = '{k, 12'hFFF, 10, 1'b0};
              ign[k] = 1'b1;
            end else begin
              cur[k] = sb.pop_front();
              ign[k] = 1'b0;
              if (cur[k].b2b) begin
                checks++;
                if (gap[k] != 0) begin
                  errors++;
                  $display("FAIL b2b_gap inst=%0d idle_ticks=%0d required=0", k, gap[k]);
                end
              end
            end
            in_frame[k] = 1'b1;
            samp[k]     = 0;
            obs[k]      = '0;
            incons[k]   = 1'b0;
          end else begin
            gap[k]++;
          end
        end
        if (in_frame[k]) begin
          if (samp[k] % R == 0) obs[k][samp[k] / R] = dout[k];
          else if (obs[k][samp[k] / R] != dout[k]) incons[k] = 1'b1;
          samp[k]++;
          if (samp[k] == cur[k].nbits * R) begin
            in_frame[k] = 1'b0;
            gap[k]      = 0;
            frames[k]++;
            if (!ign[k]) begin
              checks++;
              if (incons[k] || obs[k] != cur[k].seq) begin
                errors++;
                $display("FAIL frame inst=%0d got=%b want=%b level_changed_mid_bit=%0b",
                         k, obs[k], cur[k].seq, incons[k]);
              end
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic push(input int k, input logic [11:0] seq, input int nbits, input bit b2b);
    sb.push_back('{k, seq, nbits, b2b});
  endtask

  task automatic send(input int k, input logic [7:0] d);
    int n = 0;
    tx_data     = d;
    tx_valid[k] = 1'b1;
    while (!tx_ready[k] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout inst=%0d tx_ready=0 after %0d cycles, required 1", k, n);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(input int k);
    int n = 0;
    while ((sb.size() != 0 || busy[k] || !tx_ready[k]) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL drain_timeout inst=%0d busy=%0b queued=%0d, required idle", k, busy[k], sb.size());
    end
    repeat (4) @(negedge clk);
  endtask

  logic held;
  int   dc;

  initial begin
    repeat (3) @(posedge clk);
    #1 check("reset_state", {dout, tx_ready, busy, tx_done}, {4'hF, 4'hF, 4'h0, 4'h0});
    @(posedge clk) #2 rst = 1'b0;
    @(negedge clk);

    // single frame 8'hA5: 0,1,0,1,0,0,1,0,1,1
    push(0, 10'b1_1010_0101_0, 10, 1'b0);
    send(0, 8'hA5);
    tx_valid[0] = 1'b0;
    wait_done(0);

    // back-to-back 8'h55, 8'h0F with valid held
    push(0, 10'b1_0101_0101_0, 10, 1'b0);
    push(0, 10'b1_0000_1111_0, 10, 1'b1);
    send(0, 8'h55);
    send(0, 8'h0F);
    tx_valid[0] = 1'b0;
    wait_done(0);

    // parity: 8'h07 even -> 1, odd -> 0
    push(1, 11'b1_1_0000_0111_0, 11, 1'b0);
    send(1, 8'h07);
    tx_valid[1] = 1'b0;
    wait_done(1);
    push(2, 11'b1_0_0000_0111_0, 11, 1'b0);
    send(2, 8'h07);
    tx_valid[2] = 1'b0;
    wait_done(2);

    // two stop bits, buffer and shifter both occupied
    push(3, 11'b11_1100_0011_0, 11, 1'b0);
    push(3, 11'b11_1000_0001_0, 11, 1'b1);
    send(3, 8'hC3);
    send(3, 8'h81);
    tx_valid[3] = 1'b0;
    check("ready_full_a", {31'd0, tx_ready[3]}, 32'd0);
    repeat (100) @(negedge clk);
    check("ready_full_b", {31'd0, tx_ready[3]}, 32'd0);
    wait_done(3);

    // tick stall mid-bit
    push(0, 10'b1_0011_1100_0, 10, 1'b0);
    send(0, 8'h3C);
    tx_valid[0] = 1'b0;
    repeat (200) @(negedge clk);
    @(posedge clk) #1 tick_stall = 1'b1;
    held = dout[0];
    check("stall_busy", {31'd0, busy[0]}, 32'd1);
    repeat (100) @(posedge clk);
    #1 check("stall_hold", {31'd0, dout[0]}, {31'd0, held});
    tick_stall = 1'b0;
    @(negedge clk);
    wait_done(0);

    // reset mid-DATA with a word waiting in the buffer
    push(0, 10'b1_0101_1010_0, 10, 1'b0);
    send(0, 8'h5A);
    send(0, 8'h11);
    tx_valid[0] = 1'b0;
    repeat (300) @(negedge clk);
    check("rst_pre_busy", {31'd0, busy[0]}, 32'd1);
    dc = done_cnt[0];
    @(posedge clk) #2 rst = 1'b1;
    #1 check("rst_async", {28'd0, dout[0], tx_ready[0], busy[0], tx_done[0]}, 32'b1100);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (1000) @(negedge clk);
    check("rst_no_done", dc, done_cnt[0]);
    check("rst_idle", {30'd0, dout[0], tx_ready[0]}, 32'b11);

    check("done_plain", done_cnt[0], 4);
    check("done_even",  done_cnt[1], 1);
    check("done_odd",   done_cnt[2], 1);
    check("done_stop2", done_cnt[3], 2);
    check("frames_plain", frames[0], 4);
    check("frames_stop2", frames[3], 2);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
